// File: rtl/sub_pkg.sv
// Shared FSM state encoding and default operand width for the serial subtractor.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial x - y, LSB first, one bit per cycle; results held until the next accepted start.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic [CW-1:0]    cnt;
    logic             bflop, ovf_r, xmsb, ymsb;
    logic             d, bout, last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    full_subtractor_1 u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bflop),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            cnt     <= '0;
            bflop   <= 1'b0;
            ovf_r   <= 1'b0;
            xmsb    <= 1'b0;
            ymsb    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr  <= x;
                    b_sr  <= y;
                    cnt   <= '0;
                    bflop <= 1'b0;
                    ovf_r <= 1'b0;
                    xmsb  <= x[WIDTH-1];
                    ymsb  <= y[WIDTH-1];
                end
                RUN: begin
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    diff_sr <= {d, diff_sr[WIDTH-1:1]};
                    bflop   <= bout;
                    cnt     <= cnt + CW'(1);
                    // On the last bit, d is the result MSB, so overflow is decided here.
                    if (last_bit) ovf_r <= (xmsb != ymsb) && (d != xmsb);
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign diff   = diff_sr;
    assign borrow = bflop;
    assign ovf    = ovf_r;

endmodule
